fir_mac_decim: RTL and testbench
================================

// Module: fir_mac_decim
// PURPOSE
//  Decimating FIR MAC engine, directly downstream of the 256x18 coefficient ROM.
//  Stores incoming I/Q samples in an internal circular buffer.
//  On every DECIM-th sample it runs one TAPS-long multiply-accumulate pass, addressing
//  the coefficient ROM itself, and emits one rounded, saturated I/Q output.
//  Sits between the CIC decimator output and the receiver output FIFO.
// PARAMETERS
//  TAPS    256  number of taps; equals the coefficient ROM depth; power of two
//  DECIM   8    decimation ratio: input samples per output sample
//  IN_W    24   signed input sample width
//  COEF_W  18   signed coefficient width; matches ROM q width
//  OUT_W   24   signed output sample width
//  ACC_W   50   accumulator width (IN_W+COEF_W+8)
// PORTS
//  clock       in   1       single clock; all logic rising-edge
//  reset_n     in   1       synchronous, active-low reset
//  in_strobe   in   1       one-cycle valid for in_i/in_q
//  in_i        in   IN_W    signed I sample
//  in_q        in   IN_W    signed Q sample
//  coef_addr   out  8       ROM address, log2(TAPS) bits
//  coef_q      in   COEF_W  ROM data; valid 1 cycle after coef_addr (registered ROM)
//  out_strobe  out  1       one-cycle valid for out_i/out_q
//  out_i       out  OUT_W   filtered, decimated I
//  out_q       out  OUT_W   filtered, decimated Q
//  busy        out  1       MAC pass in progress
//  overrun     out  1       sticky: a pass trigger arrived while busy
// BEHAVIOUR
//  Reset (reset_n low at a clock edge) clears all outputs, the write pointer, the
//   decimation counter, the accumulators and the FSM; state returns to IDLE.
//   Sample buffer contents are not cleared. Reset aborts any pass with no output.
//  Sample buffer: 2*TAPS entries per rail, registered read port.
//   Every in_strobe writes at wp, then wp increments modulo 2*TAPS.
//   Writes are never blocked, including during a pass.
//  Decimation counter runs 0..DECIM-1 and increments on each in_strobe.
//   The strobe that wraps it from DECIM-1 to 0 is the trigger; sample n is the sample
//   written in that cycle (call it t0).
//  FSM states: IDLE -> MAC -> FLUSH -> OUT -> IDLE.
//   IDLE: on trigger at t0, latch base=wp (pre-increment) and go to MAC at t0+1.
//   MAC: lasts TAPS cycles (t0+1..t0+TAPS). Cycle k issues coef_addr=k and
//    buffer read address (base-k) mod 2*TAPS.
//   Pipeline: ROM and buffer data valid 1 cycle after the address; product registered
//    1 cycle later; acc += product on the next edge. Coefficient k multiplies x[n-k].
//   FLUSH: 2 cycles to drain the pipeline.
//   OUT: output register is loaded; out_strobe is high for exactly one cycle at
//    t0+TAPS+3; busy is low from the next cycle.
//  busy is high in cycles t0+1..t0+TAPS+3 inclusive.
//  The accumulator clears on entry to MAC. Products are full IN_W+COEF_W signed.
//   Accumulation wraps at ACC_W; with the chosen ACC_W this cannot occur.
//  Output scaling: y = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round-half-up.
//   y then saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  out_i and out_q hold their value between strobes. coef_addr holds 0 outside MAC.
//  A trigger while busy (not IDLE): the pass is dropped, overrun is set, and the sample
//   is still stored. overrun clears only on reset.
//  A trigger in the same cycle as OUT is treated as "while busy".
//  The I and Q rails share coef_q and run in lockstep.
// TESTING
//  Use a ROM model with 1-cycle registered read; TAPS=256, DECIM=8 unless noted.
//  1. Impulse: coef[k]=k+1; one sample of 131072 (2^17) followed by zeros.
//     -> successive outputs equal coef at offsets 7,15,...: 8, 16, 24, ...
//  2. DC: all coef=1024, all inputs I=1000, Q=-1000 after buffer fill.
//     -> out_i=2000, out_q=-2000 on every strobe.
//  3. Saturation: coef all 131071, inputs all 8388607.
//     -> out_i=8388607. Negated inputs -> out_i=-8388608.
//  4. Latency/decimation: 64 in_strobes spaced 300 cycles apart.
//     -> 8 out_strobes, each exactly 259 cycles after its trigger; busy width 259.
//  5. Overrun: in_strobes every cycle.
//     -> overrun rises at the second trigger and stays high; outputs continue, one per
//        completed pass.
//  6. Reset mid-pass at t0+100.
//     -> no out_strobe; busy=0, out_i=0, coef_addr=0; the next trigger completes normally.

Source files
------------

// File: rtl/fir_mac_decim.sv
// Decimating FIR MAC engine: buffers I/Q samples in a circular RAM and, on every
// DECIM-th sample, runs one TAPS-long MAC pass against an external registered coefficient ROM.
module fir_mac_decim #(
    parameter int TAPS   = 256,
    parameter int DECIM  = 8,
    parameter int IN_W   = 24,
    parameter int COEF_W = 18,
    parameter int OUT_W  = 24,
    parameter int ACC_W  = 50
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_strobe,
    input  logic [IN_W-1:0]          in_i,
    input  logic [IN_W-1:0]          in_q,
    output logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_q,
    output logic                     out_strobe,
    output logic [OUT_W-1:0]         out_i,
    output logic [OUT_W-1:0]         out_q,
    output logic                     busy,
    output logic                     overrun
);
    localparam int AW    = $clog2(TAPS);
    localparam int BW    = AW + 1;
    localparam int DEPTH = 2 * TAPS;
    localparam int PW    = IN_W + COEF_W;
    localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_W - 2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   wp_q, wp_d;
    logic [BW-1:0]   base_q, base_d;
    logic [CW-1:0]   dec_q, dec_d;
    logic            overrun_q, overrun_d;
    logic            out_strobe_q, out_strobe_d;
    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic            trigger;
    logic            clr_acc;
    logic            load_out;
    logic [BW-1:0]   rd_addr;
    logic signed [COEF_W-1:0] coef_s;

    assign coef_s  = $signed(coef_q);
    assign rd_addr = base_q - BW'(cnt_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wp_d         = wp_q;
        base_d       = base_q;
        dec_d        = dec_q;
        overrun_d    = overrun_q;
        out_strobe_d = 1'b0;
        v1_d         = (state_q == S_MAC);
        v2_d         = v1_q;
        clr_acc      = 1'b0;
        load_out     = 1'b0;
        trigger      = in_strobe && (dec_q == CW'(DECIM - 1));

        if (in_strobe) begin
            wp_d  = wp_q + BW'(1);
            dec_d = (dec_q == CW'(DECIM - 1)) ? '0 : dec_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    base_d  = wp_q;
                    cnt_d   = '0;
                    clr_acc = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (cnt_q == AW'(TAPS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_FLUSH: begin
                // Second flush cycle: the last product lands in acc on this edge,
                // so the output register samples the post-add value.
                if (cnt_q == AW'(1)) begin
                    cnt_d        = '0;
                    load_out     = 1'b1;
                    out_strobe_d = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (trigger && (state_q != S_IDLE))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wp_q         <= '0;
            base_q       <= '0;
            dec_q        <= '0;
            overrun_q    <= 1'b0;
            out_strobe_q <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wp_q         <= wp_d;
            base_q       <= base_d;
            dec_q        <= dec_d;
            overrun_q    <= overrun_d;
            out_strobe_q <= out_strobe_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
        end
    end

    // Rail 0 is I, rail 1 is Q; both share the control path and coefficient stream.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rail
        logic [IN_W-1:0]          din;
        logic [IN_W-1:0]          mem [DEPTH];
        logic signed [IN_W-1:0]   rd_q;
        logic signed [PW-1:0]     prod_q, prod_d;
        logic signed [ACC_W-1:0]  acc_q, acc_d;
        logic signed [ACC_W-1:0]  rnd_full, scaled;
        logic signed [OUT_W-1:0]  y_sat;
        logic signed [OUT_W-1:0]  outv_q, outv_d;

        assign din = (gi == 0) ? in_i : in_q;

        always_ff @(posedge clock) begin
            if (in_strobe)
                mem[wp_q] <= din;
            rd_q   <= mem[rd_addr];
            prod_q <= prod_d;
        end

        always_comb begin
            prod_d = PW'(rd_q) * PW'(coef_s);

            acc_d = acc_q;
            if (clr_acc)
                acc_d = '0;
            else if (v2_q)
                acc_d = acc_q + ACC_W'(prod_q);

            rnd_full = acc_d + RND;
            scaled   = rnd_full >>> (COEF_W - 1);
            if (scaled > SAT_MAX)
                y_sat = SAT_MAX[OUT_W-1:0];
            else if (scaled < SAT_MIN)
                y_sat = SAT_MIN[OUT_W-1:0];
            else
                y_sat = scaled[OUT_W-1:0];

            outv_d = outv_q;
            if (load_out)
                outv_d = y_sat;
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                acc_q  <= '0;
                outv_q <= '0;
            end else begin
                acc_q  <= acc_d;
                outv_q <= outv_d;
            end
        end
    end

    assign out_i      = g_rail[0].outv_q;
    assign out_q      = g_rail[1].outv_q;
    assign out_strobe = out_strobe_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign coef_addr  = (state_q == S_MAC) ? cnt_q : '0;

endmodule

// File: tb/tb_fir_mac_decim.sv
// Scoreboard bench for fir_mac_decim: directed stimulus pushes hand-derived outputs and
// their due cycle; an independent monitor pops and compares on every out_strobe.
module tb_fir_mac_decim;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_strobe = 1'b0;
    logic [23:0] in_i = '0;
    logic [23:0] in_q = '0;
    logic [7:0]  coef_addr;
    logic [17:0] coef_q = '0;
    logic        out_strobe;
    logic [23:0] out_i;
    logic [23:0] out_q;
    logic        busy;
    logic        overrun;

    fir_mac_decim dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_strobe  (in_strobe),
        .in_i       (in_i),
        .in_q       (in_q),
        .coef_addr  (coef_addr),
        .coef_q     (coef_q),
        .out_strobe (out_strobe),
        .out_i      (out_i),
        .out_q      (out_q),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Registered coefficient ROM: data follows the address by one clock.
    int coef_mem [256];
    always @(posedge clock) coef_q <= 18'(coef_mem[coef_addr]);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int ei;
        int eq;
        int et;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ignore_out = 1'b0;
    bit   bw_chk = 1'b0;
    int   bw = 0;
    int   scount = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (out_strobe && !ignore_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got out_i=%0d out_q=%0d at cycle %0d, expected no output",
                         $signed(out_i), $signed(out_q), cyc);
            end else begin
                e = sb.pop_front();
                $display("out cycle %0d: out_i=%0d out_q=%0d (exp %0d %0d @%0d)",
                         cyc, $signed(out_i), $signed(out_q), e.ei, e.eq, e.et);
                check("out_i", int'($signed(out_i)), e.ei);
                check("out_q", int'($signed(out_q)), e.eq);
                check("out_cycle", cyc, e.et);
            end
        end
    end

    always @(negedge clock) begin
        if (busy) begin
            bw++;
        end else begin
            if (bw > 0 && bw_chk)
                check("busy_width", bw, 259);
            bw = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before cycle 100000");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        scount  = 0;
    endtask

    // Trigger strobes (every 8th since reset) expect an output 259 cycles later.
    task automatic strobe(input int si, input int sq, input bit expect_out,
                          input int ei, input int eq, input int gap);
        in_strobe = 1'b1;
        in_i = 24'(si);
        in_q = 24'(sq);
        if (expect_out && (scount % 8 == 7))
            sb.push_back(exp_t'{ei, eq, cyc + 259});
        scount++;
        tick(1);
        in_strobe = 1'b0;
        if (gap > 1)
            tick(gap - 1);
    endtask

    // Overwrite the whole sample buffer, then reset to clear state and overrun.
    task automatic fill(input int vi, input int vq);
        ignore_out = 1'b1;
        for (int k = 0; k < 512; k++)
            strobe(vi, vq, 1'b0, 0, 0, 1);
        tick(2);
        do_reset();
        tick(2);
        ignore_out = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) coef_mem[k] = 0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("rst_out_strobe", int'(out_strobe), 0);
        check("rst_out_i", int'($signed(out_i)), 0);
        check("rst_out_q", int'($signed(out_q)), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_coef_addr", int'(coef_addr), 0);

        // Impulse at sample 0: output at sample s (s = 7, 15, ...) is coef[s] = s+1.
        for (int k = 0; k < 256; k++) coef_mem[k] = k + 1;
        fill(0, 0);
        for (int s = 0; s < 32; s++)
            strobe((s == 0) ? 131072 : 0, (s == 0) ? -131072 : 0, 1'b1, s + 1, -(s + 1), 270);
        tick(300);

        // DC plus latency/decimation: 256*1000*1024 / 2^17 = 2000 exactly.
        for (int k = 0; k < 256; k++) coef_mem[k] = 1024;
        fill(1000, -1000);
        bw_chk = 1'b1;
        for (int s = 0; s < 64; s++)
            strobe(1000, -1000, 1'b1, 2000, -2000, 300);
        tick(300);
        bw_chk = 1'b0;
        check("overrun_spaced", int'(overrun), 0);

        // Back-to-back strobes: passes accepted at triggers i = 7, 271, 535 only.
        for (int i = 0; i < 600; i++) begin
            strobe(1000, -1000, (i == 7) || (i == 271) || (i == 535), 2000, -2000, 1);
            if (i == 14) check("overrun_before_2nd", int'(overrun), 0);
            if (i == 15) check("overrun_at_2nd", int'(overrun), 1);
        end
        tick(900);
        check("overrun_sticky", int'(overrun), 1);

        // Reset during a pass at t0+100: pass aborted, everything cleared.
        for (int i = 0; i < 8; i++)
            strobe(1000, -1000, 1'b0, 0, 0, 1);
        tick(98);
        check("busy_mid_pass", int'(busy), 1);
        tick(1);
        check("coef_addr_mid_pass", int'(coef_addr), 99);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        scount = 0;
        check("abort_busy", int'(busy), 0);
        check("abort_out_i", int'($signed(out_i)), 0);
        check("abort_coef_addr", int'(coef_addr), 0);
        check("abort_overrun", int'(overrun), 0);
        tick(300);
        for (int i = 0; i < 8; i++)
            strobe(1000, -1000, 1'b1, 2000, -2000, 1);
        tick(300);

        // Saturation at both rails' extremes.
        for (int k = 0; k < 256; k++) coef_mem[k] = 131071;
        fill(8388607, -8388607);
        for (int i = 0; i < 8; i++)
            strobe(8388607, -8388607, 1'b1, 8388607, -8388608, 1);
        tick(300);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
